// File: rtl/xge_stat_toggle_gen_if.sv
// Status event / fault bundle between the XGMII-rx status sources and the toggle encoder.
interface xge_stat_toggle_gen_if #(
    parameter int unsigned DWIDTH = 8
);
    logic [DWIDTH-1:0] evt_pulse;
    logic              fault_local_in;
    logic              fault_remote_in;
    logic [DWIDTH-1:0] tog_out;
    logic              status_local_fault_crx;
    logic              status_remote_fault_crx;
    logic [DWIDTH-1:0] evt_coalesced;

    modport master (
        output evt_pulse,
        output fault_local_in,
        output fault_remote_in,
        input  tog_out,
        input  status_local_fault_crx,
        input  status_remote_fault_crx,
        input  evt_coalesced
    );

    modport slave (
        input  evt_pulse,
        input  fault_local_in,
        input  fault_remote_in,
        output tog_out,
        output status_local_fault_crx,
        output status_remote_fault_crx,
        output evt_coalesced
    );
endinterface

// File: rtl/xge_stat_toggle_gen.sv
// Turns status event pulses into spaced per-bit toggles for the Wishbone-side synchronizer.
// Define XGE_STAT_HOLD_EN to build the minimum-spacing / one-deep queue / coalesce logic.
module xge_stat_toggle_gen #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned HOLD   = 4
) (
    input logic                   clk_xgmii_rx,
    input logic                   reset_xgmii_rx_n,
    xge_stat_toggle_gen_if.slave  stat
);

    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("HOLD must be in 1..15");
    end

    logic [DWIDTH-1:0] tog_q, tog_d;
    logic [DWIDTH-1:0] coal_q;
    logic              fault_local_q, fault_remote_q;

`ifdef XGE_STAT_HOLD_EN
    localparam logic [3:0] Reload = 4'(HOLD - 1);

    logic [DWIDTH-1:0]      pend_q, pend_d;
    logic [DWIDTH-1:0]      coal_d;
    logic [DWIDTH-1:0][3:0] cnt_q, cnt_d;

    always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
        if (!reset_xgmii_rx_n) begin
            tog_q  <= '0;
            pend_q <= '0;
            coal_q <= '0;
            cnt_q  <= '0;
        end else begin
            tog_q  <= tog_d;
            pend_q <= pend_d;
            coal_q <= coal_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        tog_d  = tog_q;
        pend_d = pend_q;
        coal_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < DWIDTH; i++) begin
            if (cnt_q[i] == 4'd0) begin
                if (stat.evt_pulse[i] || pend_q[i]) begin
                    // A pulse arriving with a release is queued behind it.
                    tog_d[i]  = ~tog_q[i];
                    cnt_d[i]  = Reload;
                    pend_d[i] = stat.evt_pulse[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] - 4'd1;
                if (stat.evt_pulse[i]) begin
                    if (pend_q[i]) coal_d[i] = 1'b1;
                    else           pend_d[i] = 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
        if (!reset_xgmii_rx_n) begin
            tog_q <= '0;
        end else begin
            tog_q <= tog_d;
        end
    end

    always_comb begin
        tog_d = tog_q ^ stat.evt_pulse;
    end

    assign coal_q = '0;
`endif

    always_ff @(posedge clk_xgmii_rx or negedge reset_xgmii_rx_n) begin
        if (!reset_xgmii_rx_n) begin
            fault_local_q  <= 1'b0;
            fault_remote_q <= 1'b0;
        end else begin
            fault_local_q  <= stat.fault_local_in;
            fault_remote_q <= stat.fault_remote_in;
        end
    end

    always_comb begin
        stat.tog_out                 = tog_q;
        stat.evt_coalesced           = coal_q;
        stat.status_local_fault_crx  = fault_local_q;
        stat.status_remote_fault_crx = fault_remote_q;
    end

endmodule

// File: tb/tb_xge_stat_toggle_gen.sv
// Bench for xge_stat_toggle_gen: directed vector table, corner sequences, random vs. timing model.
module tb_xge_stat_toggle_gen;
    localparam int unsigned DW   = 8;
    localparam int unsigned HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    xge_stat_toggle_gen_if #(.DWIDTH(DW)) bus ();

    xge_stat_toggle_gen #(.DWIDTH(DW), .HOLD(HOLD)) dut (
        .clk_xgmii_rx     (clk),
        .reset_xgmii_rx_n (rst_n),
        .stat             (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks the cycle of each bit's last toggle, not a down-counter.
    logic [7:0] m_tog, m_coal, m_pend;
    logic       m_fl, m_fr;
    int         m_last [DW];
    int         m_cyc;

    task automatic model_reset();
        m_tog = '0; m_coal = '0; m_pend = '0; m_fl = 1'b0; m_fr = 1'b0; m_cyc = 0;
        for (int i = 0; i < DW; i++) m_last[i] = -1000;
    endtask

    task automatic model_edge(input logic [7:0] evt, input logic fl, input logic fr);
`ifdef XGE_STAT_HOLD_EN
        m_coal = '0;
        for (int i = 0; i < DW; i++) begin
            if (evt[i] || m_pend[i]) begin
                if (m_cyc - m_last[i] >= int'(HOLD)) begin
                    m_tog[i]  = ~m_tog[i];
                    m_last[i] = m_cyc;
                    m_pend[i] = evt[i];
                end else if (evt[i]) begin
                    if (m_pend[i]) m_coal[i] = 1'b1;
                    else           m_pend[i] = 1'b1;
                end
            end
        end
`else
        m_tog  = m_tog ^ evt;
        m_coal = '0;
`endif
        m_fl = fl;
        m_fr = fr;
        m_cyc++;
    endtask

    task automatic cycle(input logic [7:0] evt, input logic fl, input logic fr);
        bus.evt_pulse       = evt;
        bus.fault_local_in  = fl;
        bus.fault_remote_in = fr;
        @(posedge clk);
        #1;
        model_edge(evt, fl, fr);
    endtask

    task automatic check_model(input string tag);
        check({tag, " tog"},  bus.tog_out, m_tog);
        check({tag, " coal"}, bus.evt_coalesced, m_coal);
        check({tag, " flt_l"}, {7'd0, bus.status_local_fault_crx}, {7'd0, m_fl});
        check({tag, " flt_r"}, {7'd0, bus.status_remote_fault_crx}, {7'd0, m_fr});
    endtask

    task automatic check_zero(input string tag);
        check({tag, " tog"},  bus.tog_out, 8'h00);
        check({tag, " coal"}, bus.evt_coalesced, 8'h00);
        check({tag, " flt_l"}, {7'd0, bus.status_local_fault_crx}, 8'h00);
        check({tag, " flt_r"}, {7'd0, bus.status_remote_fault_crx}, 8'h00);
    endtask

    task automatic do_reset();
        bus.evt_pulse = '0; bus.fault_local_in = 1'b0; bus.fault_remote_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] evt;
        logic       fl;
        logic       fr;
        logic [7:0] tog_h;   // expected with hold logic built
        logic [7:0] coal_h;
        logic [7:0] tog_n;   // expected without hold logic
    } vec_t;

    vec_t tab [17];

    initial begin
        logic [7:0] prev, exp_tog, exp_coal, rnd;
        int         tog_cnt, coal_cnt, exp_tcnt, exp_ccnt;

        tab[0]  = '{8'h40, 1'b0, 1'b0, 8'h40, 8'h00, 8'h40};
        tab[1]  = '{8'h01, 1'b0, 1'b0, 8'h41, 8'h00, 8'h41};
        tab[2]  = '{8'h01, 1'b0, 1'b0, 8'h41, 8'h00, 8'h40};
        tab[3]  = '{8'h01, 1'b0, 1'b0, 8'h41, 8'h01, 8'h41};
        tab[4]  = '{8'h00, 1'b1, 1'b0, 8'h41, 8'h00, 8'h41};
        tab[5]  = '{8'h00, 1'b1, 1'b1, 8'h40, 8'h00, 8'h41};
        tab[6]  = '{8'h00, 1'b1, 1'b0, 8'h40, 8'h00, 8'h41};
        tab[7]  = '{8'h08, 1'b0, 1'b0, 8'h48, 8'h00, 8'h49};
        tab[8]  = '{8'h08, 1'b0, 1'b0, 8'h48, 8'h00, 8'h41};
        tab[9]  = '{8'h00, 1'b0, 1'b0, 8'h48, 8'h00, 8'h41};
        tab[10] = '{8'h00, 1'b0, 1'b0, 8'h48, 8'h00, 8'h41};
        tab[11] = '{8'h08, 1'b0, 1'b0, 8'h40, 8'h00, 8'h49};
        tab[12] = '{8'h00, 1'b0, 1'b1, 8'h40, 8'h00, 8'h49};
        tab[13] = '{8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 8'h49};
        tab[14] = '{8'h00, 1'b0, 1'b0, 8'h40, 8'h00, 8'h49};
        tab[15] = '{8'h00, 1'b0, 1'b0, 8'h48, 8'h00, 8'h49};
        tab[16] = '{8'h00, 1'b0, 1'b0, 8'h48, 8'h00, 8'h49};

        bus.evt_pulse = '0; bus.fault_local_in = 1'b0; bus.fault_remote_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Directed vector table
        do_reset();
        for (int k = 0; k < 17; k++) begin
            cycle(tab[k].evt, tab[k].fl, tab[k].fr);
`ifdef XGE_STAT_HOLD_EN
            exp_tog  = tab[k].tog_h;
            exp_coal = tab[k].coal_h;
`else
            exp_tog  = tab[k].tog_n;
            exp_coal = 8'h00;
`endif
            check($sformatf("vec%0d tog", k), bus.tog_out, exp_tog);
            check($sformatf("vec%0d coal", k), bus.evt_coalesced, exp_coal);
            check($sformatf("vec%0d flt_l", k), {7'd0, bus.status_local_fault_crx},
                  {7'd0, tab[k].fl});
            check($sformatf("vec%0d flt_r", k), {7'd0, bus.status_remote_fault_crx},
                  {7'd0, tab[k].fr});
        end

        // Reset mid-hold with a queued event: nothing may toggle afterwards
        do_reset();
        cycle(8'h04, 1'b1, 1'b1);
        cycle(8'h04, 1'b1, 1'b1);
        bus.evt_pulse = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midhold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 2 * int'(HOLD); k++) begin
            cycle(8'h00, 1'b0, 1'b0);
            check_zero($sformatf("post_rst%0d", k));
        end

        // All bits pulsed every cycle for 20 cycles
        do_reset();
        prev = 8'h00; tog_cnt = 0; coal_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(8'hFF, 1'b0, 1'b0);
            check_model($sformatf("allff%0d", k));
            if (bus.tog_out[0] != prev[0]) tog_cnt++;
            if (bus.evt_coalesced[0]) coal_cnt++;
            prev = bus.tog_out;
        end
`ifdef XGE_STAT_HOLD_EN
        exp_tcnt = 5;  exp_ccnt = 15;
`else
        exp_tcnt = 20; exp_ccnt = 0;
`endif
        check("allff toggle count", 8'(tog_cnt), 8'(exp_tcnt));
        check("allff coalesce count", 8'(coal_cnt), 8'(exp_ccnt));

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rnd = 8'($urandom);
            if (k % 100 < 50) rnd = rnd & 8'($urandom) & 8'($urandom);
            cycle(rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
